fetch: RTL and testbench

Instruction-fetch stage of the single-issue MIPS core. It holds the program counter and issues one word request at a time to instruction memory over a valid/ready interface. It captures the returned word and presents it, with its PC, to the decode stage over a valid/ready interface. It also applies PC redirects (branch, jump, register jump) from the control path, discarding any wrong-path fetch. No delay slot.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_pc_next.sv | 31 +++
 rtl/fetch.sv | 119 +++++++++++
 tb/tb_fetch.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths and PC-source encodings for the fetch stage and its redirect logic.
// Combinational definitions only; no latency or flow control lives here.
// Decode produces pc_src with these same encodings.
package fetch_pkg;

  localparam int W_CPU    = 32;
  localparam int W_IMM    = 16;
  localparam int W_JADDR  = 26;
  localparam int W_PC_SRC = 2;

  localparam logic [W_PC_SRC-1:0] PC_SRC_NEXT = 2'd0;
  localparam logic [W_PC_SRC-1:0] PC_SRC_BRCH = 2'd1;
  localparam logic [W_PC_SRC-1:0] PC_SRC_JUMP = 2'd2;
  localparam logic [W_PC_SRC-1:0] PC_SRC_REGF = 2'd3;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Redirect target calculator: next, branch, jump and register-jump targets.
// Purely combinational, zero cycles.
// No flow control; the result is consumed only when redirect is asserted.
module pc_next
  import fetch_pkg::*;
(
  input  logic [W_PC_SRC-1:0] pc_src,
  input  logic [31:0]         redir_pc,
  input  logic [W_IMM-1:0]    redir_imm,
  input  logic [W_JADDR-1:0]  redir_jaddr,
  input  logic [31:0]         redir_reg,
  output logic [31:0]         target
);

  logic [31:0] p4;
  logic [31:0] brch_off;

  assign p4       = redir_pc + 32'd4;
  assign brch_off = {{(32-W_IMM-2){redir_imm[W_IMM-1]}}, redir_imm, 2'b00};

  always_comb begin
    target = p4;
    case (pc_src)
      PC_SRC_BRCH: target = p4 + brch_off;
      PC_SRC_JUMP: target = {p4[31:28], redir_jaddr, 2'b00};
      PC_SRC_REGF: target = word_align(redir_reg);
      default:     target = p4;
    endcase
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem request, holds the returned word for decode.
// Latency: request accepted at N, response N+1 earliest, inst_valid at N+2; 3-cycle loop.
// Backpressure: FULL holds inst/inst_pc until inst_ready; no new request meanwhile.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  output logic [31:0]         imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  logic [W_CPU-1:0]    imem_rsp_data,
  output logic [W_CPU-1:0]    inst,
  output logic [31:0]         inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                redirect,
  input  logic [W_PC_SRC-1:0] pc_src,
  input  logic [31:0]         redir_pc,
  input  logic [W_IMM-1:0]    redir_imm,
  input  logic [W_JADDR-1:0]  redir_jaddr,
  input  logic [31:0]         redir_reg
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FULL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        drop;
  logic        drop_nxt;
  logic        capture;
  logic [31:0] target;

  pc_next u_pc_next (
    .pc_src      (pc_src),
    .redir_pc    (redir_pc),
    .redir_imm   (redir_imm),
    .redir_jaddr (redir_jaddr),
    .redir_reg   (redir_reg),
    .target      (target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= word_align(RESET_PC);
      drop    <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      if (capture) begin
        inst    <= imem_rsp_data;
        inst_pc <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    capture   = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        // The address may move before acceptance; once accepted with a
        // redirect, the in-flight word belongs to the old path.
        if (redirect) pc_nxt = target;
        if (imem_req_ready) begin
          state_nxt = ST_WAIT;
          drop_nxt  = redirect;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_nxt   = target;
          drop_nxt = 1'b1;
        end
        if (imem_rsp_valid) begin
          drop_nxt = 1'b0;
          if (drop || redirect) begin
            state_nxt = ST_REQ;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = ST_REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem_req_valid = (state == ST_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == ST_FULL);

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: straight-line fetch, backpressure, redirects in each state, async reset.
// Memory model answers each accepted request after mem_lat cycles with data = addr ^ 32'h3C00_0000.
module tb_fetch;
  import fetch_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                imem_req_valid;
  logic [31:0]         imem_req_addr;
  logic                imem_req_ready = 1'b0;
  logic                imem_rsp_valid = 1'b0;
  logic [W_CPU-1:0]    imem_rsp_data = '0;
  logic [W_CPU-1:0]    inst;
  logic [31:0]         inst_pc;
  logic                inst_valid;
  logic                inst_ready = 1'b0;
  logic                redirect = 1'b0;
  logic [W_PC_SRC-1:0] pc_src = PC_SRC_NEXT;
  logic [31:0]         redir_pc = '0;
  logic [W_IMM-1:0]    redir_imm = '0;
  logic [W_JADDR-1:0]  redir_jaddr = '0;
  logic [31:0]         redir_reg = '0;

  int errs = 0;
  int checks = 0;
  int mem_lat = 1;
  int cyc = 0;

  logic [31:0] req_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] inst_q[$];
  int          cyc_q[$];

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect       (redirect),
    .pc_src         (pc_src),
    .redir_pc       (redir_pc),
    .redir_imm      (redir_imm),
    .redir_jaddr    (redir_jaddr),
    .redir_reg      (redir_reg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && imem_req_valid && imem_req_ready) req_q.push_back(imem_req_addr);
    if (!rst && inst_valid && inst_ready) begin
      pc_q.push_back(inst_pc);
      inst_q.push_back(inst);
      cyc_q.push_back(cyc);
    end
  end

  // Memory keeps answering across reset so late responses can be observed.
  initial begin
    bit          acc;
    bit          pend;
    int          cnt;
    logic [31:0] acc_addr;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    forever begin
      @(posedge clk);
      acc = !rst && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (acc) begin
        pend = 1'b1;
        cnt = mem_lat;
        paddr = acc_addr;
      end
      if (pend) begin
        if (cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = paddr ^ 32'h3C00_0000;
          pend = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int n, output bit ok, output bit saw_valid);
    ok = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inst_valid) saw_valid = 1'b1;
      if (req_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cons(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pc_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req_valid, inst_valid, inst, inst_pc, imem_req_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      errs++;
      $display("FAIL reset_outputs: got req_v=%b inst_v=%b inst=%h pc=%h addr=%h want 0,0,0,0,0",
               imem_req_valid, inst_valid, inst, inst_pc, imem_req_addr);
    end
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL idle_no_req: got %b want 0", imem_req_valid);
    end
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      errs++;
      $display("FAIL first_req: got v=%b addr=%h want v=1 addr=00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_straight();
    int rb;
    int pb;
    bit ok;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    rb = req_q.size();
    pb = pc_q.size();
    wait_cons(pb + 3, ok);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL straight_timeout: got %0d consumed want 3", pc_q.size() - pb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_q[rb+i] !== 32'(i * 4) || pc_q[pb+i] !== 32'(i * 4)) begin
          errs++;
          $display("FAIL straight_addr%0d: got req=%h pc=%h want %h", i, req_q[rb+i], pc_q[pb+i], 32'(i * 4));
        end
      end
      checks++;
      if (inst_q[pb+1] !== 32'h3C00_0004) begin
        errs++;
        $display("FAIL straight_inst: got %h want 3c000004", inst_q[pb+1]);
      end
      checks++;
      if (cyc_q[pb+2] - cyc_q[pb+1] !== 3) begin
        errs++;
        $display("FAIL straight_throughput: got %0d cycles want 3", cyc_q[pb+2] - cyc_q[pb+1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int rb;
    bit ok;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    do_reset();
    rb = req_q.size();
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL bp_timeout: got no inst_valid want inst_valid");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({inst_valid, imem_req_valid, inst_pc, inst} !== {1'b1, 1'b0, 32'h0, 32'h3C00_0000}) begin
        errs++;
        $display("FAIL bp_hold%0d: got v=%b req=%b pc=%h inst=%h want 1,0,00000000,3c000000",
                 i, inst_valid, imem_req_valid, inst_pc, inst);
      end
    end
    checks++;
    if (req_q.size() - rb !== 1) begin
      errs++;
      $display("FAIL bp_one_req: got %0d requests want 1", req_q.size() - rb);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h4, 1'b0}) begin
      errs++;
      $display("FAIL bp_next_req: got v=%b addr=%h inst_v=%b want 1,00000004,0", imem_req_valid, imem_req_addr, inst_valid);
    end
  endtask

  task automatic test_branch();
    bit ok;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    do_reset();
    wait_valid(ok);
    redirect = 1'b1;
    pc_src = PC_SRC_BRCH;
    redir_pc = 32'h0000_0100;
    redir_imm = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0000_00FC}) begin
      errs++;
      $display("FAIL branch_target: got v=%b req=%b addr=%h want 0,1,000000fc", inst_valid, imem_req_valid, imem_req_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || inst_pc !== 32'h0000_00FC || inst !== 32'h3C00_00FC) begin
      errs++;
      $display("FAIL branch_inst: got pc=%h inst=%h want 000000fc 3c0000fc", inst_pc, inst);
    end
    redirect = 1'b1;
    pc_src = PC_SRC_JUMP;
    redir_pc = 32'hF000_0000;
    redir_jaddr = 26'h10;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hF000_0040}) begin
      errs++;
      $display("FAIL jump_target: got v=%b addr=%h want 1 f0000040", imem_req_valid, imem_req_addr);
    end
    wait_valid(ok);
    redirect = 1'b1;
    pc_src = PC_SRC_NEXT;
    redir_pc = 32'h0000_003C;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0040}) begin
      errs++;
      $display("FAIL next_target: got v=%b addr=%h want 1 00000040", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    int rb;
    int pb;
    bit ok;
    bit saw;
    mem_lat = 3;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    rb = req_q.size();
    pb = pc_q.size();
    wait_req(rb + 1, ok, saw);
    redirect = 1'b1;
    pc_src = PC_SRC_REGF;
    redir_reg = 32'h0000_0203;
    @(negedge clk);
    redirect = 1'b0;
    wait_req(rb + 2, ok, saw);
    checks++;
    if (!ok || saw !== 1'b0) begin
      errs++;
      $display("FAIL wait_drop: got ok=%b inst_valid_seen=%b want ok=1 seen=0", ok, saw);
    end
    checks++;
    if (req_q[rb+1] !== 32'h0000_0200) begin
      errs++;
      $display("FAIL wait_target: got %h want 00000200", req_q[rb+1]);
    end
    wait_cons(pb + 1, ok);
    checks++;
    if (!ok || pc_q[pb] !== 32'h0000_0200 || inst_q[pb] !== 32'h3C00_0200) begin
      errs++;
      $display("FAIL wait_first_inst: got pc=%h inst=%h want 00000200 3c000200", pc_q[pb], inst_q[pb]);
    end
  endtask

  task automatic test_redirect_ready();
    int rb;
    int pb;
    bit ok;
    bit saw;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    rb = req_q.size();
    pb = pc_q.size();
    @(negedge clk);
    redirect = 1'b1;
    pc_src = PC_SRC_BRCH;
    redir_pc = 32'h0000_0200;
    redir_imm = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    wait_req(rb + 2, ok, saw);
    checks++;
    if (!ok || saw !== 1'b0 || req_q[rb] !== 32'h0 || req_q[rb+1] !== 32'h0000_0304) begin
      errs++;
      $display("FAIL rdy_redirect: got ok=%b seen=%b req0=%h req1=%h want 1,0,00000000,00000304",
               ok, saw, req_q[rb], req_q[rb+1]);
    end
    wait_cons(pb + 1, ok);
    checks++;
    if (!ok || pc_q[pb] !== 32'h0000_0304) begin
      errs++;
      $display("FAIL rdy_first_inst: got %h want 00000304", pc_q[pb]);
    end
    imem_req_ready = 1'b0;
    do_reset();
    rb = req_q.size();
    pb = pc_q.size();
    @(negedge clk);
    redirect = 1'b1;
    pc_src = PC_SRC_NEXT;
    redir_pc = 32'h0000_003C;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0040}) begin
      errs++;
      $display("FAIL req_retarget: got v=%b addr=%h want 1 00000040", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    wait_cons(pb + 1, ok);
    checks++;
    if (!ok || req_q[rb] !== 32'h0000_0040 || pc_q[pb] !== 32'h0000_0040) begin
      errs++;
      $display("FAIL req_retarget_inst: got req=%h pc=%h want 00000040", req_q[rb], pc_q[pb]);
    end
  endtask

  task automatic test_async_reset();
    int rb;
    int pb;
    bit ok;
    bit saw;
    mem_lat = 3;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    rb = req_q.size();
    pb = pc_q.size();
    wait_cons(pb + 1, ok);
    wait_req(rb + 2, ok, saw);
    checks++;
    if (!ok || imem_req_addr !== 32'h4 || inst !== 32'h3C00_0000) begin
      errs++;
      $display("FAIL arst_pre: got addr=%h inst=%h want 00000004 3c000000", imem_req_addr, inst);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req_valid, inst_valid, imem_req_addr, inst, inst_pc} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      errs++;
      $display("FAIL arst_immediate: got req_v=%b inst_v=%b addr=%h inst=%h pc=%h want all 0",
               imem_req_valid, inst_valid, imem_req_addr, inst, inst_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_cons(pb + 2, ok);
    checks++;
    if (!ok || req_q[rb+2] !== 32'h0 || pc_q[pb+1] !== 32'h0 || inst_q[pb+1] !== 32'h3C00_0000) begin
      errs++;
      $display("FAIL arst_restart: got req=%h pc=%h inst=%h want 00000000 00000000 3c000000",
               req_q[rb+2], pc_q[pb+1], inst_q[pb+1]);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_branch();
    test_redirect_wait();
    test_redirect_ready();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
